jstepper: RTL and testbench
===========================

# jstepper

Parametrised clocked step sequencer. It divides the system clock into 4-phase steps and drives one-hot step lines plus an enable strobe (`wclk_e`) and a set strobe (`wclk_s`) for the gate-level datapath. It is the control-timing successor to the combinational gate library (`jand`, `jor`, `jandN`, `jorN`). It sits between the clock source and the instruction decoder. Depth is generic, and it adds halt and early-restart behaviour.

## Interface
- `N`, default 6: number of steps per sequence; legal range 2..16.
- `wclk` input, 1 bit: system clock; all state updates on its rising edge.
- `wreset` input, 1 bit: reset, synchronous and active-high.
- `whalt` input, 1 bit: holds the sequencer at the start of the current step.
- `wrestart` input, 1 bit: ends the current sequence after the current step. Present only with `JSTEPPER_RESTART_EN`.
- `wsteps` output, N bits: one-hot current step; bit 0 is the first step.
- `wclk_e` output, 1 bit: enable strobe.
- `wclk_s` output, 1 bit: set strobe.
- `wlast` output, 1 bit: high while step N-1 is active.

## Operation
- State: step index (0..N-1) and phase (P0..P3, one-hot register).
- Phase sequence per step is P0 → P1 → P2 → P3 → P0 of the next step.
- Strobe decode by phase:
  - P0: `wclk_e`=0, `wclk_s`=0.
  - P1: `wclk_e`=1, `wclk_s`=0.
  - P2: `wclk_e`=1, `wclk_s`=1.
  - P3: `wclk_e`=1, `wclk_s`=0.
  - `wclk_s` is always nested inside `wclk_e`.
- Step advance happens only on P3 → P0:
  - step k → k+1;
  - step N-1 → 0 (wrap);
  - `wsteps` is the one-hot of the step index.
- Halt:
  - `whalt` is sampled only in P0. If high, the phase stays P0 and the step is unchanged, so no strobes are emitted.
  - Advance resumes on the first P0 cycle with `whalt`=0.
  - `whalt` in P1..P3 is ignored, so a started step always completes.
- Restart:
  - `wrestart` is sampled only in P3. If high, the next step is 0 regardless of the current step.
  - Ignored in P0..P2.
  - `wrestart` during step N-1 gives step 0, identical to a normal wrap.
- Reset:
  - `wreset`=1 at any edge, including mid-step or while halted, forces step 0, P0, `wsteps`=1, `wclk_e`=0, `wclk_s`=0, `wlast`=(N==1 ? 1 : 0). Since N≥2, `wlast`=0.
  - Reset has priority over `whalt` and `wrestart`.
- All outputs come directly from registers. There is no combinational path from inputs to outputs.

## Timing
- First cycle after reset release: P0 of step 0.
- Unhalted step length: 4 `wclk` cycles. Full sequence: 4·N cycles.
- `wclk_e` is high 3 cycles per step; `wclk_s` is high 1 cycle per step, in the middle cycle of `wclk_e`.
- Input-to-state latency:
  - `whalt` high seen in P0 stretches that P0 by one cycle per halted cycle.
  - `wrestart` seen in P3 makes the next cycle P0 of step 0.
- `wlast` changes in the same cycle as `wsteps`.

## Configuration
- `JSTEPPER_RESTART_EN` defined: the `wrestart` port exists with the behaviour above.
- `JSTEPPER_RESTART_EN` undefined:
  - the port is absent;
  - sequences always run all N steps;
  - the restart mux is not generated.

## Structure
- Phase encodings (`JPH_P0`..`JPH_P3`, 4-bit one-hot) and `JSTEPPER_NMAX`=16 are defined in `src/defs.v`.
- Sub-module `jphase4`: a 4-phase ring holding the phase register and strobe decode, with input `whold`.
  - Outputs: `wp3` (end-of-step pulse), `wclk_e`, `wclk_s`.
- The step register, wrap, restart logic and `wlast` live in `jstepper`.
- Strobe decode and `wlast` use `jand`/`jor`/`jorN` gates.

## Test plan
- Reset, then run 24 cycles with N=6:
  - `wsteps` is 000001 for cycles 0-3, 000010 for 4-7, …, 100000 for 20-23, then 000001 at cycle 24;
  - `wlast` is high for cycles 20-23.
- Strobe shape over one step:
  - `wclk_e` pattern 0,1,1,1;
  - `wclk_s` pattern 0,0,1,0;
  - `wclk_s`=1 never occurs with `wclk_e`=0 (assertion over the whole run).
- Halt:
  - `whalt`=1 for 5 cycles starting at P0 of step 2: `wsteps`=000100 and both strobes stay 0 for 5 extra cycles, then a normal 4-cycle step.
  - `whalt` pulsed in P2: no effect.
- Restart (macro on):
  - `wrestart`=1 in P3 of step 2 → next cycle `wsteps`=000001, P0.
  - `wrestart` in P1: ignored.
  - `wrestart` in P3 of step 5: wraps to step 0.
- Reset mid-operation:
  - `wreset`=1 in P2 of step 4 → next cycle `wsteps`=000001, `wclk_e`=0, `wclk_s`=0.
  - With `wreset` and `whalt` both high, the reset values take effect.
- Parameter sweep:
  - N=2 → sequence length 8 cycles, with `wlast` alternating every 4 cycles;
  - N=16 → sequence length 64 cycles.

Source files
------------

// File: rtl/jstepper_pkg.sv
// jstepper_pkg: shared definitions for the jstepper step sequencer.
// Holds the one-hot phase encodings, the maximum supported depth and the
// small gate-level helper functions (jand / jor / jorn) used by the strobe
// and last-step decode, so the decode reads like the gate library it replaces.
package jstepper_pkg;

   // Largest legal number of steps per sequence.
   localparam int JSTEPPER_NMAX = 16;

   // Four-phase ring, one-hot encoded.
   typedef enum logic [3:0] {
      JPH_P0 = 4'b0001,
      JPH_P1 = 4'b0010,
      JPH_P2 = 4'b0100,
      JPH_P3 = 4'b1000
   } jphase_t;

   // Two-input AND gate.
   function automatic logic jand(input logic a, input logic b);
      return a & b;
   endfunction

   // Two-input OR gate.
   function automatic logic jor(input logic a, input logic b);
      return a | b;
   endfunction

   // Wide OR gate over up to JSTEPPER_NMAX inputs; unused inputs tied low.
   function automatic logic jorn(input logic [JSTEPPER_NMAX-1:0] v);
      return |v;
   endfunction

endpackage

// File: rtl/jstepper_phase4.sv
// jphase4: four-phase ring for the step sequencer.
// The phase advances P0 -> P1 -> P2 -> P3 -> P0 every clock. While whold is
// high in P0 the ring parks in P0; a hold seen in P1..P3 is ignored so that a
// started step always completes. The strobes and the end-of-step flag are
// decoded from the upcoming phase and registered, so every output comes
// straight from a flop and the strobes line up with the phase register.
module jphase4
   import jstepper_pkg::*;
(
   input  logic wclk,
   input  logic wreset,
   input  logic whold,
   output logic wp3,
   output logic wclk_e,
   output logic wclk_s
);

   jphase_t phase;
   jphase_t phase_next;
   logic    e_next;
   logic    s_next;
   logic    p3_next;

   // State register: phase plus registered strobes, synchronous reset to P0.
   always_ff @(posedge wclk) begin
      if (wreset) begin
         phase  <= JPH_P0;
         wclk_e <= 1'b0;
         wclk_s <= 1'b0;
         wp3    <= 1'b0;
      end else begin
         phase  <= phase_next;
         wclk_e <= e_next;
         wclk_s <= s_next;
         wp3    <= p3_next;
      end
   end

   // Next-phase logic: hold only in P0, any illegal code recovers to P0.
   always_comb begin
      phase_next = JPH_P0;
      case (phase)
         JPH_P0: begin
            if (whold) begin
               phase_next = JPH_P0;
            end else begin
               phase_next = JPH_P1;
            end
         end
         JPH_P1:  phase_next = JPH_P2;
         JPH_P2:  phase_next = JPH_P3;
         JPH_P3:  phase_next = JPH_P0;
         default: phase_next = JPH_P0;
      endcase
   end

   // Strobe decode of the upcoming phase; wclk_s is gated by wclk_e so it
   // can never appear outside the enable window.
   always_comb begin
      e_next  = jorn({13'b0, phase_next[3], phase_next[2], phase_next[1]});
      s_next  = jand(phase_next[2], e_next);
      p3_next = jand(phase_next[3], 1'b1);
   end

endmodule

// File: rtl/jstepper.sv
// jstepper: parametrised clocked step sequencer.
// Divides wclk into 4-phase steps and drives the one-hot step lines, the
// enable/set strobes and the last-step flag. The phase ring lives in jphase4;
// this module holds the step index, the wrap and restart selection and wlast.
// Optional feature macro: JSTEPPER_RESTART_EN adds the wrestart port, which
// ends the current sequence after the current step when seen in P3.
module jstepper
   import jstepper_pkg::*;
#(
   parameter int N = 6
) (
   input  logic         wclk,
   input  logic         wreset,
   input  logic         whalt,
`ifdef JSTEPPER_RESTART_EN
   input  logic         wrestart,
`endif
   output logic [N-1:0] wsteps,
   output logic         wclk_e,
   output logic         wclk_s,
   output logic         wlast
);

   localparam int IW = (N > 2) ? $clog2(N) : 1;

   logic [IW-1:0] step;
   logic [IW-1:0] step_next;
   logic [N-1:0]  steps_next;
   logic          wlast_next;
   logic          at_wrap;
   logic          wp3;

   // Phase ring and strobes; whalt only takes effect while parked in P0.
   jphase4 u_phase (
      .wclk   (wclk),
      .wreset (wreset),
      .whold  (whalt),
      .wp3    (wp3),
      .wclk_e (wclk_e),
      .wclk_s (wclk_s)
   );

   // Step selection: move on only at the P3 -> P0 boundary.
   always_comb begin
      step_next = step;
      at_wrap   = (step == IW'(N - 1));
      if (wp3) begin
`ifdef JSTEPPER_RESTART_EN
         if (jor(wrestart, at_wrap)) begin
            step_next = {IW{1'b0}};
         end else begin
            step_next = step + IW'(1);
         end
`else
         if (at_wrap) begin
            step_next = {IW{1'b0}};
         end else begin
            step_next = step + IW'(1);
         end
`endif
      end else begin
         step_next = step;
      end
   end

   // One-hot decode of the next step and the last-step flag derived from it.
   always_comb begin
      steps_next = {N{1'b0}};
      for (int i = 0; i < N; i++) begin
         if (step_next == IW'(i)) begin
            steps_next[i] = 1'b1;
         end else begin
            steps_next[i] = 1'b0;
         end
      end
      wlast_next = jand(steps_next[N-1], 1'b1);
   end

   // Step register and registered step outputs; reset returns to step 0.
   always_ff @(posedge wclk) begin
      if (wreset) begin
         step   <= {IW{1'b0}};
         wsteps <= {{(N-1){1'b0}}, 1'b1};
         wlast  <= 1'b0;
      end else begin
         step   <= step_next;
         wsteps <= steps_next;
         wlast  <= wlast_next;
      end
   end

endmodule

// File: tb/tb_jstepper.sv
// tb_jstepper: directed scoreboard bench for jstepper.
// The stimulus process drives one cycle at a time and pushes the expected
// outputs for that cycle; a monitor on the falling edge pops and compares.
// Three instances run side by side: N=6 (main, exercised with halt, restart
// and reset), and N=2 / N=16 free-running for the depth sweep.
module tb_jstepper;

   logic clk = 1'b0;
   logic rst;
   logic rst_p;
   logic halt;
`ifdef JSTEPPER_RESTART_EN
   logic restart;
`endif

   logic [5:0]  steps;
   logic        e, s, last;
   logic [1:0]  steps2;
   logic        e2, s2, last2;
   logic [15:0] steps16;
   logic        e16, s16, last16;

   typedef struct packed {
      logic [5:0]  st;
      logic        e;
      logic        s;
      logic        l;
      logic [1:0]  st2;
      logic        e2;
      logic        s2;
      logic        l2;
      logic [15:0] st16;
      logic        l16;
   } exp_t;

   exp_t q[$];
   exp_t x;
   int   vectors     = 0;
   int   miscompares = 0;
   int   cyc         = 0;

   always #5 clk = ~clk;

   jstepper #(.N(6)) dut (
      .wclk     (clk),
      .wreset   (rst),
      .whalt    (halt),
`ifdef JSTEPPER_RESTART_EN
      .wrestart (restart),
`endif
      .wsteps   (steps),
      .wclk_e   (e),
      .wclk_s   (s),
      .wlast    (last)
   );

   jstepper #(.N(2)) dut2 (
      .wclk     (clk),
      .wreset   (rst_p),
      .whalt    (1'b0),
`ifdef JSTEPPER_RESTART_EN
      .wrestart (1'b0),
`endif
      .wsteps   (steps2),
      .wclk_e   (e2),
      .wclk_s   (s2),
      .wlast    (last2)
   );

   jstepper #(.N(16)) dut16 (
      .wclk     (clk),
      .wreset   (rst_p),
      .whalt    (1'b0),
`ifdef JSTEPPER_RESTART_EN
      .wrestart (1'b0),
`endif
      .wsteps   (steps16),
      .wclk_e   (e16),
      .wclk_s   (s16),
      .wlast    (last16)
   );

   // One cycle: record what should be visible now, then drive the inputs
   // sampled at the next rising edge.
   task automatic tick(input logic r, input logic h, input int idx, input int ph);
      exp_t        y;
      logic [3:0]  e_pat = 4'b1110;
      logic [3:0]  s_pat = 4'b0100;
      logic [5:0]  one6  = 6'b000001;
      logic [1:0]  one2  = 2'b01;
      logic [15:0] one16 = 16'h0001;
      int          k2, k16, ph2;
      k2    = (cyc / 4) % 2;
      k16   = (cyc / 4) % 16;
      ph2   = cyc % 4;
      y.st  = one6 << idx;
      y.e   = e_pat[ph];
      y.s   = s_pat[ph];
      y.l   = (idx == 5);
      y.st2 = one2 << k2;
      y.e2  = e_pat[ph2];
      y.s2  = s_pat[ph2];
      y.l2  = (k2 == 1);
      y.st16 = one16 << k16;
      y.l16 = (k16 == 15);
      q.push_back(y);
      rst   = r;
      rst_p = 1'b0;
      halt  = h;
      cyc++;
      @(posedge clk);
      #1;
   endtask

   // A whole step, optionally held in P0 for hold_n extra cycles and with
   // whalt pulsed in the phases flagged by hmask (bits 1..3).
   task automatic run_step(input int idx, input int hold_n, input logic [3:0] hmask);
      for (int i = 0; i < hold_n; i++) tick(1'b0, 1'b1, idx, 0);
      for (int ph = 0; ph < 4; ph++) tick(1'b0, hmask[ph], idx, ph);
   endtask

`ifdef JSTEPPER_RESTART_EN
   // A whole step with wrestart raised in phase rph (4 means never).
   task automatic rstep(input int idx, input int rph);
      for (int ph = 0; ph < 4; ph++) begin
         restart = (ph == rph);
         tick(1'b0, 1'b0, idx, ph);
      end
      restart = 1'b0;
   endtask
`endif

   // Monitor: compare each instance against the expectation for this cycle.
   always @(negedge clk) begin
      if (q.size() > 0) begin
         x = q.pop_front();
         vectors++;
         if ({steps, e, s, last} !== {x.st, x.e, x.s, x.l}) begin
            miscompares++;
            $display("FAIL main t=%0t: got steps=%b e=%b s=%b last=%b, want steps=%b e=%b s=%b last=%b",
                     $time, steps, e, s, last, x.st, x.e, x.s, x.l);
         end
         vectors++;
         if ({steps2, e2, s2, last2} !== {x.st2, x.e2, x.s2, x.l2}) begin
            miscompares++;
            $display("FAIL n2 t=%0t: got steps=%b e=%b s=%b last=%b, want steps=%b e=%b s=%b last=%b",
                     $time, steps2, e2, s2, last2, x.st2, x.e2, x.s2, x.l2);
         end
         vectors++;
         if ({steps16, last16} !== {x.st16, x.l16}) begin
            miscompares++;
            $display("FAIL n16 t=%0t: got steps=%b last=%b, want steps=%b last=%b",
                     $time, steps16, last16, x.st16, x.l16);
         end
      end
      if ((s === 1'b1 && e !== 1'b1) || (s16 === 1'b1 && e16 !== 1'b1)) begin
         miscompares++;
         $display("FAIL nesting t=%0t: got s=%b e=%b s16=%b e16=%b, want set strobe only inside enable",
                  $time, s, e, s16, e16);
      end
   end

   // Directed stimulus.
   initial begin
      rst   = 1'b1;
      rst_p = 1'b1;
      halt  = 1'b0;
`ifdef JSTEPPER_RESTART_EN
      restart = 1'b0;
`endif
      repeat (2) @(posedge clk);
      #1;

      // Plain sequence: six 4-cycle steps, then wrap to step 0.
      for (int i = 0; i < 6; i++) run_step(i, 0, 4'b0000);

      // Halt 5 cycles at P0 of step 2; halt pulsed in P2 of step 3 ignored.
      run_step(0, 0, 4'b0000);
      run_step(1, 0, 4'b0000);
      run_step(2, 5, 4'b0000);
      run_step(3, 0, 4'b0100);
      run_step(4, 0, 4'b0000);
      run_step(5, 0, 4'b0000);

`ifdef JSTEPPER_RESTART_EN
      // Restart in P3 of step 2, ignored in P1, and in P3 of the last step.
      rstep(0, 4);
      rstep(1, 4);
      rstep(2, 3);
      rstep(0, 1);
      rstep(1, 4);
      rstep(2, 4);
      rstep(3, 4);
      rstep(4, 4);
      rstep(5, 3);
`endif

      // Reset in P2 of step 4.
      for (int i = 0; i < 4; i++) run_step(i, 0, 4'b0000);
      tick(1'b0, 1'b0, 4, 0);
      tick(1'b0, 1'b0, 4, 1);
      tick(1'b1, 1'b0, 4, 2);
      run_step(0, 0, 4'b0000);
      run_step(1, 0, 4'b0000);
      run_step(2, 0, 4'b0000);

      // Reset and halt together at P0 of step 3: reset wins.
      tick(1'b1, 1'b1, 3, 0);
      run_step(0, 0, 4'b0000);
      run_step(1, 0, 4'b0000);

      @(negedge clk);
      #1;
      vectors++;
      if (q.size() != 0) begin
         miscompares++;
         $display("FAIL drain: got %0d pending expectations, want 0", q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
